// File: rtl/genie_split_pkg.sv
// Shared defaults for the genie_split broadcast node and its port interface.
// The optional per-packet mask lock is controlled by GENIE_SPLIT_PKT_LOCK_EN in genie_split.sv.
package genie_split_pkg;

  localparam int unsigned DEFAULT_NO    = 2;
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/genie_split_if.sv
// Stream bundle for genie_split: one valid/ready/eop input plus NO per-output valid/ready lanes.
// slave = the split node itself, master = the surrounding logic that drives and consumes it.
interface genie_split_if
  import genie_split_pkg::*;
#(
  parameter int unsigned NO    = DEFAULT_NO,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_eop;
  logic [NO-1:0]    i_mask;
  logic [NO-1:0]    o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_eop;
  logic [NO-1:0]    i_ready;

  modport slave (
    input  i_data, i_valid, i_eop, i_mask, i_ready,
    output o_ready, o_valid, o_data, o_eop
  );

  modport master (
    output i_data, i_valid, i_eop, i_mask, i_ready,
    input  o_ready, o_valid, o_data, o_eop
  );

endinterface

// File: rtl/genie_split.sv
// Zero-latency broadcast node: replicates each input beat onto the outputs selected by its mask.
// Define GENIE_SPLIT_PKT_LOCK_EN to latch the mask of a packet's first beat for the whole packet.
module genie_split
  import genie_split_pkg::*;
#(
  parameter int unsigned NO    = DEFAULT_NO,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  genie_split_if.slave  bus
);

  logic [NO-1:0]    r_done;
  logic [NO-1:0]    w_effMask;
  logic [NO-1:0]    w_valid;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;

`ifdef GENIE_SPLIT_PKT_LOCK_EN
  logic          r_inPkt;
  logic [NO-1:0] r_pktMask;

  assign w_effMask = r_inPkt ? r_pktMask : bus.i_mask;
`else
  assign w_effMask = bus.i_mask;
`endif

  // An output is offered the beat only until it has taken it once.
  assign w_valid  = {NO{bus.i_valid}} & w_effMask & ~r_done;
  assign w_ready  = &(~w_effMask | r_done | bus.i_ready);
  assign w_accept = bus.i_valid & w_ready;
  assign w_data   = bus.i_data;

  assign bus.o_valid = w_valid;
  assign bus.o_ready = w_ready;
  assign bus.o_data  = w_data;
  assign bus.o_eop   = bus.i_eop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= '0;
    end else if (w_accept) begin
      r_done <= '0;
    end else begin
      r_done <= r_done | (w_valid & bus.i_ready);
    end
  end

`ifdef GENIE_SPLIT_PKT_LOCK_EN
  // Single-beat packets carry eop on their first beat and so never enter the locked state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inPkt   <= 1'b0;
      r_pktMask <= '0;
    end else if (w_accept) begin
      if (bus.i_eop) begin
        r_inPkt <= 1'b0;
      end else if (!r_inPkt) begin
        r_inPkt   <= 1'b1;
        r_pktMask <= bus.i_mask;
      end
    end
  end
`endif

endmodule
